// File: rtl/array_6_pkg.sv
// Shared constants and state type for the array_6 requester-side controller.
package array_6_pkg;

    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned AW         = 10;
    localparam int unsigned DW         = 13;
    localparam int unsigned RESP_DEPTH = 2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/array_6_req_ctrl_if.sv
// Request/response handshakes plus the SRAM macro R0/W0 strobes.
interface array_6_req_ctrl_if;
    import array_6_pkg::*;

    logic          w_valid;
    logic          w_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          r_valid;
    logic          r_ready;
    logic [AW-1:0] r_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          init_done;
    logic          sram_ren;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;
    logic          sram_wen;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;

    // Requester and macro model side.
    modport master (
        output w_valid, w_addr, w_data, r_valid, r_addr, resp_ready, sram_rdata,
        input  w_ready, r_ready, resp_valid, resp_data, init_done,
        input  sram_ren, sram_raddr, sram_wen, sram_waddr, sram_wdata
    );

    // Controller side.
    modport slave (
        input  w_valid, w_addr, w_data, r_valid, r_addr, resp_ready, sram_rdata,
        output w_ready, r_ready, resp_valid, resp_data, init_done,
        output sram_ren, sram_raddr, sram_wen, sram_waddr, sram_wdata
    );

endinterface

// File: rtl/array_6_resp_queue.sv
// Two-entry response FIFO; a push into an empty queue is visible the next cycle.
module array_6_resp_queue
    import array_6_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem_q [RESP_DEPTH];
    logic          wptr_q;
    logic          rptr_q;
    logic [1:0]    count_q;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= push_data;
                wptr_q        <= ~wptr_q;
            end
            if (pop_ok) begin
                rptr_q <= ~rptr_q;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/array_6_req_ctrl.sv
// Requester-side driver for the 1024x13 1R1W SRAM: clear sweep, write/read strobes,
// write-first collision bypass and a 2-entry read response queue.
module array_6_req_ctrl
    import array_6_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    array_6_req_ctrl_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          inflight_q;
    logic          byp_valid_q;
    logic [DW-1:0] byp_data_q;
    logic [AW-1:0] raddr_q;

    logic          w_ready, r_ready, w_fire, r_fire, pop, run;
    logic          sram_wen;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;
    logic [1:0]    q_count;
    logic [DW-1:0] q_head;
    logic [2:0]    occupancy;

    assign run    = (state_q == S_RUN);
    assign pop    = (q_count != 2'd0) && bus.resp_ready;
    assign w_fire = bus.w_valid && w_ready;
    assign r_fire = bus.r_valid && r_ready;

    // Slots already committed once this cycle's pop is taken into account.
    assign occupancy = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign r_ready   = run && (occupancy < 3'd2);
    assign w_ready   = run;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sram_wen   = 1'b0;
        sram_waddr = '0;
        sram_wdata = '0;
        unique case (state_q)
            S_RST: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
            S_INIT: begin
                sram_wen   = 1'b1;
                sram_waddr = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_RUN: begin
                sram_wen   = w_fire;
                sram_waddr = bus.w_addr;
                sram_wdata = bus.w_data;
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inflight_q  <= r_fire;
            // The macro returns old data on a same-address collision; forward the write.
            byp_valid_q <= r_fire && w_fire && (bus.w_addr == bus.r_addr);
            byp_data_q  <= bus.w_data;
            if (r_fire) begin
                raddr_q <= bus.r_addr;
            end
        end
    end

    array_6_resp_queue u_resp_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (byp_valid_q ? byp_data_q : bus.sram_rdata),
        .pop       (pop),
        .count     (q_count),
        .head      (q_head)
    );

    assign bus.w_ready    = w_ready;
    assign bus.r_ready    = r_ready;
    assign bus.resp_valid = (q_count != 2'd0);
    assign bus.resp_data  = q_head;
    assign bus.init_done  = run;
    assign bus.sram_ren   = r_fire;
    assign bus.sram_raddr = r_fire ? bus.r_addr : raddr_q;
    assign bus.sram_wen   = sram_wen;
    assign bus.sram_waddr = sram_waddr;
    assign bus.sram_wdata = sram_wdata;

endmodule

// File: tb/tb_array_6_req_ctrl.sv
// Directed bench for array_6_req_ctrl with a behavioural 1R1W macro model.
module tb_array_6_req_ctrl;
    import array_6_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    array_6_req_ctrl_if bus ();

    array_6_req_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Macro model: read returns pre-write contents on a same-cycle collision.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.sram_wen) mem[bus.sram_waddr] <= bus.sram_wdata;
        if (bus.sram_ren) bus.sram_rdata <= mem[bus.sram_raddr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.w_valid = 1'b0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        bus.r_valid = 1'b0;
        bus.r_addr  = '0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.w_valid = 1'b1;
        bus.w_addr  = a;
        bus.w_data  = d;
        tick();
        bus.w_valid = 1'b0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if (!(bus.sram_wen === 1'b1 && bus.sram_waddr === AW'(i) && bus.sram_wdata === '0
                  && bus.w_ready === 1'b0 && bus.r_ready === 1'b0 && bus.init_done === 1'b0))
            begin
                errors++;
                $display("FAIL sweep[%0d]: got wen=%b waddr=%h wdata=%h wr=%b rr=%b done=%b, want 1 %h 0 0 0 0",
                         i, bus.sram_wen, bus.sram_waddr, bus.sram_wdata, bus.w_ready,
                         bus.r_ready, bus.init_done, AW'(i));
            end
        end
        tick();
        checks++;
        if (!(bus.init_done === 1'b1 && bus.w_ready === 1'b1 && bus.r_ready === 1'b1
              && bus.sram_wen === 1'b0)) begin
            errors++;
            $display("FAIL sweep_end: got done=%b wr=%b rr=%b wen=%b, want 1 1 1 0",
                     bus.init_done, bus.w_ready, bus.r_ready, bus.sram_wen);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        bus.resp_ready = 1'b0;
        #3;
        checks++;
        if ({bus.sram_wen, bus.sram_ren, bus.init_done, bus.resp_valid, bus.w_ready,
             bus.r_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got wen=%b ren=%b done=%b rv=%b wr=%b rr=%b, want all 0",
                     bus.sram_wen, bus.sram_ren, bus.init_done, bus.resp_valid,
                     bus.w_ready, bus.r_ready);
        end
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.sram_wen !== 1'b0 || bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_cycle0: got wen=%b done=%b, want 0 0", bus.sram_wen, bus.init_done);
        end
        test_sweep();
    endtask

    task automatic test_write_read();
        bus.resp_ready = 1'b1;
        bus.w_valid = 1'b1;
        bus.w_addr  = 10'd5;
        bus.w_data  = 13'h1ABC;
        #1;
        checks++;
        if (bus.sram_wen !== 1'b1 || bus.sram_waddr !== 10'd5 || bus.sram_wdata !== 13'h1ABC) begin
            errors++;
            $display("FAIL write_strobe: got wen=%b waddr=%h wdata=%h, want 1 005 1abc",
                     bus.sram_wen, bus.sram_waddr, bus.sram_wdata);
        end
        tick();
        bus.w_valid = 1'b0;
        bus.r_valid = 1'b1;
        bus.r_addr  = 10'd5;
        #1;
        checks++;
        if (bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'd5) begin
            errors++;
            $display("FAIL read_strobe: got ren=%b raddr=%h, want 1 005", bus.sram_ren, bus.sram_raddr);
        end
        tick();
        // A later write to the same address must not disturb the captured read.
        bus.r_valid = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_data  = 13'h0777;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.sram_ren !== 1'b0 || bus.sram_raddr !== 10'd5) begin
            errors++;
            $display("FAIL read_n1: got rv=%b ren=%b raddr=%h, want 0 0 005",
                     bus.resp_valid, bus.sram_ren, bus.sram_raddr);
        end
        tick();
        bus.w_valid = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 13'h1ABC) begin
            errors++;
            $display("FAIL read_resp: got rv=%b data=%h, want 1 1abc", bus.resp_valid, bus.resp_data);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_drain: got rv=%b, want 0", bus.resp_valid);
        end
    endtask

    task automatic test_collision();
        bus.w_valid = 1'b1;
        bus.w_addr  = 10'h3FF;
        bus.w_data  = 13'h0155;
        bus.r_valid = 1'b1;
        bus.r_addr  = 10'h3FF;
        #1;
        checks++;
        if (bus.sram_wen !== 1'b1 || bus.sram_ren !== 1'b1) begin
            errors++;
            $display("FAIL coll_strobes: got wen=%b ren=%b, want 1 1", bus.sram_wen, bus.sram_ren);
        end
        tick();
        clear_inputs();
        tick();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 13'h0155) begin
            errors++;
            $display("FAIL coll_resp: got rv=%b data=%h, want 1 0155", bus.resp_valid, bus.resp_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) write_word(AW'(i), DW'(13'h11 * i));
        bus.r_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.r_addr = AW'(i);
            #1;
            checks++;
            if (bus.r_ready !== (i < 3)) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b, want %b", i, bus.r_ready, i < 3);
            end
            tick();
        end
        checks++;
        if (bus.r_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_data !== 13'h0011) begin
            errors++;
            $display("FAIL bp_full: got rr=%b rv=%b data=%h, want 0 1 0011",
                     bus.r_ready, bus.resp_valid, bus.resp_data);
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.r_ready !== 1'b1 || bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'd3) begin
            errors++;
            $display("FAIL bp_pop_accept: got rr=%b ren=%b raddr=%h, want 1 1 003",
                     bus.r_ready, bus.sram_ren, bus.sram_raddr);
        end
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 13'h0022) begin
            errors++;
            $display("FAIL bp_second: got rv=%b data=%h, want 1 0022", bus.resp_valid, bus.resp_data);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 13'h0033) begin
            errors++;
            $display("FAIL bp_third: got rv=%b data=%h, want 1 0033", bus.resp_valid, bus.resp_data);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got rv=%b, want 0", bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) write_word(AW'(10 + i), DW'(13'h100 + i));
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.r_valid = (k < 6);
            bus.r_addr  = AW'(10 + k);
            #1;
            if (k < 6) begin
                checks++;
                if (bus.r_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b, want 1", k, bus.r_ready);
                end
            end
            checks++;
            if (k < 2) begin
                if (bus.resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_early[%0d]: got rv=%b, want 0", k, bus.resp_valid);
                end
            end else if (bus.resp_valid !== 1'b1 || bus.resp_data !== DW'(13'h100 + k - 2)) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got rv=%b data=%h, want 1 %h",
                         k, bus.resp_valid, bus.resp_data, DW'(13'h100 + k - 2));
            end
            tick();
        end
        bus.r_valid = 1'b0;
    endtask

    task automatic read_expect(input logic [AW-1:0] a, input logic [DW-1:0] want);
        bus.resp_ready = 1'b1;
        bus.r_valid = 1'b1;
        bus.r_addr  = a;
        tick();
        bus.r_valid = 1'b0;
        tick();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== want) begin
            errors++;
            $display("FAIL post_reset_read[%h]: got rv=%b data=%h, want 1 %h",
                     a, bus.resp_valid, bus.resp_data, want);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        bus.resp_ready = 1'b0;
        bus.r_valid = 1'b1;
        bus.r_addr  = 10'd1;
        tick();
        bus.r_addr  = 10'd2;
        tick();
        bus.r_valid = 1'b0;
        tick();
        bus.resp_ready = 1'b1;
        bus.r_valid = 1'b1;
        bus.r_addr  = 10'd3;
        tick();
        bus.r_valid = 1'b0;
        bus.resp_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.resp_valid, bus.init_done, bus.w_ready, bus.r_ready, bus.sram_wen,
             bus.sram_ren} !== 6'b0) begin
            errors++;
            $display("FAIL midop_async: got rv=%b done=%b wr=%b rr=%b wen=%b ren=%b, want all 0",
                     bus.resp_valid, bus.init_done, bus.w_ready, bus.r_ready,
                     bus.sram_wen, bus.sram_ren);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        test_sweep();
        read_expect(10'd1, 13'h0000);
        read_expect(10'd5, 13'h0000);
        read_expect(10'h3FF, 13'h0000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        bus.sram_rdata = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
